buffered_fork: RTL and testbench

- Parametrised successor to the basic fork. One input stream is copied to NumOutputs output streams.
- Each output has its own Depth-entry FIFO, so a stalled consumer does not block the others until its FIFO fills.
- A per-token select mask routes each token to any subset of outputs (multicast or unicast).
- Sits between a producer and several independently paced consumers in the LLPM valid/backpressure fabric.

---
 rtl/buffered_fork.sv | 110 +++++++++++
 tb/tb_buffered_fork.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/buffered_fork.sv
// Stream fork with one circular FIFO per output; each token goes to the outputs
// flagged in its select mask, all-or-nothing, with backpressure from registered full flags only.
module buffered_fork #(
    parameter int Width      = 8,
    parameter int NumOutputs = 4,
    parameter int Depth      = 2
) (
    input  logic                                       clk,
    input  logic                                       resetn,
    input  logic [Width-1:0]                           din,
    input  logic [NumOutputs-1:0]                      din_sel,
    input  logic                                       din_valid,
    output logic                                       din_bp,
    output logic [NumOutputs*Width-1:0]                dout,
    output logic [NumOutputs-1:0]                      dout_valid,
    input  logic [NumOutputs-1:0]                      dout_bp,
    output logic [NumOutputs*($clog2(Depth)+1)-1:0]    dout_count
);

    localparam int CntW = $clog2(Depth) + 1;
    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [PtrW-1:0]  rptr_q [NumOutputs];
    logic [PtrW-1:0]  rptr_d [NumOutputs];
    logic [PtrW-1:0]  wptr_q [NumOutputs];
    logic [PtrW-1:0]  wptr_d [NumOutputs];
    logic [CntW-1:0]  cnt_q  [NumOutputs];
    logic [CntW-1:0]  cnt_d  [NumOutputs];
    logic [Width-1:0] mem_q  [NumOutputs][Depth];
    logic [Width-1:0] mem_d  [NumOutputs][Depth];

    logic [NumOutputs-1:0] full;
    logic [NumOutputs-1:0] enq;
    logic [NumOutputs-1:0] deq;
    logic                  accept;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        if (p == PtrW'(Depth - 1)) begin
            return '0;
        end
        return p + PtrW'(1);
    endfunction

    always_comb begin
        for (int unsigned i = 0; i < NumOutputs; i++) begin
            full[i]       = (cnt_q[i] == CntW'(Depth));
            dout_valid[i] = (cnt_q[i] != '0);
        end
    end

    // Reset forces bp high directly; the cleared counts alone would report "not full".
    always_comb begin
        din_bp = ~resetn | (|(din_sel & full));
        accept = din_valid & ~din_bp;
    end

    always_comb begin
        for (int unsigned i = 0; i < NumOutputs; i++) begin
            enq[i]    = accept & din_sel[i];
            deq[i]    = dout_valid[i] & ~dout_bp[i];
            rptr_d[i] = deq[i] ? ptr_inc(rptr_q[i]) : rptr_q[i];
            wptr_d[i] = enq[i] ? ptr_inc(wptr_q[i]) : wptr_q[i];
            case ({enq[i], deq[i]})
                2'b10:   cnt_d[i] = cnt_q[i] + CntW'(1);
                2'b01:   cnt_d[i] = cnt_q[i] - CntW'(1);
                default: cnt_d[i] = cnt_q[i];
            endcase
        end
    end

    always_comb begin
        mem_d = mem_q;
        for (int unsigned i = 0; i < NumOutputs; i++) begin
            if (enq[i]) begin
                mem_d[i][wptr_q[i]] = din;
            end
        end
    end

    always_comb begin
        dout       = '0;
        dout_count = '0;
        for (int unsigned i = 0; i < NumOutputs; i++) begin
            dout[i*Width +: Width]     = mem_q[i][rptr_q[i]];
            dout_count[i*CntW +: CntW] = cnt_q[i];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < NumOutputs; i++) begin
                rptr_q[i] <= '0;
                wptr_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NumOutputs; i++) begin
                rptr_q[i] <= rptr_d[i];
                wptr_q[i] <= wptr_d[i];
                cnt_q[i]  <= cnt_d[i];
            end
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_buffered_fork.sv
// Scoreboard bench for buffered_fork: instance A (Depth=2) for fork/stall/reset cases,
// instance B (Depth=4) for pointer wrap-around under a toggling consumer.
module tb_buffered_fork;

    logic        clk = 1'b0;
    logic        resetn;

    logic [7:0]  a_din;
    logic [3:0]  a_sel;
    logic        a_valid;
    logic        a_bp;
    logic [31:0] a_dout;
    logic [3:0]  a_dout_valid;
    logic [3:0]  a_dout_bp;
    logic [7:0]  a_dout_count;

    logic [7:0]  b_din;
    logic [3:0]  b_sel;
    logic        b_valid;
    logic        b_bp;
    logic [31:0] b_dout;
    logic [3:0]  b_dout_valid;
    logic [3:0]  b_dout_bp;
    logic [11:0] b_dout_count;

    int checks = 0;
    int errors = 0;
    int bmax   = 0;

    logic [7:0] qa [4][$];
    logic [7:0] qb [4][$];

    always #5 clk = ~clk;

    buffered_fork #(.Width(8), .NumOutputs(4), .Depth(2)) u_a (
        .clk(clk), .resetn(resetn), .din(a_din), .din_sel(a_sel), .din_valid(a_valid),
        .din_bp(a_bp), .dout(a_dout), .dout_valid(a_dout_valid), .dout_bp(a_dout_bp),
        .dout_count(a_dout_count)
    );

    buffered_fork #(.Width(8), .NumOutputs(4), .Depth(4)) u_b (
        .clk(clk), .resetn(resetn), .din(b_din), .din_sel(b_sel), .din_valid(b_valid),
        .din_bp(b_bp), .dout(b_dout), .dout_valid(b_dout_valid), .dout_bp(b_dout_bp),
        .dout_count(b_dout_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic push_a(input logic [7:0] d, input logic [3:0] s, output int waits);
        a_din = d; a_sel = s; a_valid = 1'b1; waits = 0;
        #1;
        while (a_bp) begin
            if (waits == 100) begin
                checks++; errors++;
                $display("FAIL push_a_timeout actual=bp_stuck required=accept data=%0h", d);
                a_valid = 1'b0;
                return;
            end
            @(negedge clk); #1; waits++;
        end
        for (int i = 0; i < 4; i++) if (s[i]) qa[i].push_back(d);
        @(negedge clk);
    endtask

    task automatic push_b(input logic [7:0] d, input logic [3:0] s, output int waits);
        b_din = d; b_sel = s; b_valid = 1'b1; waits = 0;
        #1;
        while (b_bp) begin
            if (waits == 100) begin
                checks++; errors++;
                $display("FAIL push_b_timeout actual=bp_stuck required=accept data=%0h", d);
                b_valid = 1'b0;
                return;
            end
            @(negedge clk); #1; waits++;
        end
        for (int i = 0; i < 4; i++) if (s[i]) qb[i].push_back(d);
        @(negedge clk);
    endtask

    // Monitor: pop and compare on each output handshake, and bound the counts.
    always @(negedge clk) begin
        #2;
        if (resetn) begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (a_dout_count[i*2 +: 2] > 2'd2) begin
                    errors++;
                    $display("FAIL a_count_bound out=%0d actual=%0d required<=2", i, a_dout_count[i*2 +: 2]);
                end
                checks++;
                if (b_dout_count[i*3 +: 3] > 3'd4) begin
                    errors++;
                    $display("FAIL b_count_bound out=%0d actual=%0d required<=4", i, b_dout_count[i*3 +: 3]);
                end
                if (int'(b_dout_count[i*3 +: 3]) > bmax) bmax = int'(b_dout_count[i*3 +: 3]);
                if (a_dout_valid[i] && !a_dout_bp[i]) begin
                    checks++;
                    if (qa[i].size() == 0) begin
                        errors++;
                        $display("FAIL a_unexpected out=%0d actual=%0h required=none", i, a_dout[i*8 +: 8]);
                    end else begin
                        logic [7:0] e;
                        e = qa[i].pop_front();
                        if (a_dout[i*8 +: 8] !== e) begin
                            errors++;
                            $display("FAIL a_data out=%0d actual=%0h required=%0h", i, a_dout[i*8 +: 8], e);
                        end
                    end
                end
                if (b_dout_valid[i] && !b_dout_bp[i]) begin
                    checks++;
                    if (qb[i].size() == 0) begin
                        errors++;
                        $display("FAIL b_unexpected out=%0d actual=%0h required=none", i, b_dout[i*8 +: 8]);
                    end else begin
                        logic [7:0] e;
                        e = qb[i].pop_front();
                        if (b_dout[i*8 +: 8] !== e) begin
                            errors++;
                            $display("FAIL b_data out=%0d actual=%0h required=%0h", i, b_dout[i*8 +: 8], e);
                        end
                    end
                end
            end
        end
    end

    // Upstream obligation: a stalled offer must stay unchanged until accepted.
    logic       ha, hb;
    logic [7:0] ha_d, hb_d;
    logic [3:0] ha_s, hb_s;
    initial begin ha = 1'b0; hb = 1'b0; end
    always @(posedge clk) begin
        if (ha) assert (a_valid && a_din == ha_d && a_sel == ha_s) else $error("a upstream hold violated");
        if (hb) assert (b_valid && b_din == hb_d && b_sel == hb_s) else $error("b upstream hold violated");
        ha = resetn && a_valid && a_bp; ha_d = a_din; ha_s = a_sel;
        hb = resetn && b_valid && b_bp; hb_d = b_din; hb_s = b_sel;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        resetn = 1'b0;
        a_din = '0; a_sel = '0; a_valid = 1'b0; a_dout_bp = '0;
        b_din = '0; b_sel = '0; b_valid = 1'b0; b_dout_bp = '0;

        #3;
        chk("rst_a_valid", a_dout_valid, 4'h0);
        chk("rst_a_count", a_dout_count, 8'h00);
        chk("rst_a_bp", a_bp, 1'b1);
        chk("rst_b_valid", b_dout_valid, 4'h0);
        chk("rst_b_count", b_dout_count, 12'h000);
        chk("rst_b_bp", b_bp, 1'b1);
        @(negedge clk);
        resetn = 1'b1;
        #1;
        chk("release_a_bp", a_bp, 1'b0);
        chk("release_b_bp", b_bp, 1'b0);
        @(negedge clk);

        // Broadcast with no stall
        push_a(8'h11, 4'hF, w); chk("bc_wait1", w, 0);
        chk("bc_valid1", a_dout_valid, 4'hF); chk("bc_data1", a_dout[7:0], 8'h11);
        push_a(8'h22, 4'hF, w); chk("bc_wait2", w, 0);
        chk("bc_data2", a_dout[7:0], 8'h22);
        push_a(8'h33, 4'hF, w); chk("bc_wait3", w, 0);
        chk("bc_data3", a_dout[31:24], 8'h33);
        a_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("bc_drained", a_dout_count, 8'h00);

        // Output 2 stalled
        a_dout_bp = 4'b0100;
        push_a(8'h01, 4'hF, w); chk("st_wait1", w, 0);
        push_a(8'h02, 4'hF, w); chk("st_wait2", w, 0);
        a_din = 8'h03; a_sel = 4'hF; a_valid = 1'b1;
        #1;
        chk("st_bp_full", a_bp, 1'b1);
        chk("st_count2", a_dout_count[5:4], 2'd2);
        repeat (2) @(negedge clk);
        #1;
        chk("st_bp_held", a_bp, 1'b1);
        @(negedge clk);
        a_dout_bp = 4'b0000;
        push_a(8'h03, 4'hF, w); chk("st_bubble", w, 1);
        push_a(8'h04, 4'hF, w); chk("st_wait4", w, 0);
        a_valid = 1'b0;
        repeat (5) @(negedge clk);

        // Unicast bypasses a full output
        a_dout_bp = 4'b0100;
        push_a(8'h55, 4'b0100, w);
        push_a(8'h66, 4'b0100, w);
        push_a(8'hA5, 4'b0001, w); chk("uc_wait", w, 0);
        a_valid = 1'b0;
        chk("uc_count2", a_dout_count[5:4], 2'd2);
        chk("uc_valid", a_dout_valid, 4'b0101);
        chk("uc_data0", a_dout[7:0], 8'hA5);
        @(negedge clk);
        a_dout_bp = 4'b0000;
        repeat (4) @(negedge clk);

        // Empty mask drops the token
        push_a(8'h7E, 4'h0, w); chk("em_wait", w, 0);
        a_valid = 1'b0;
        chk("em_valid", a_dout_valid, 4'h0);
        chk("em_count", a_dout_count, 8'h00);
        repeat (2) @(negedge clk);
        chk("em_valid_late", a_dout_valid, 4'h0);

        // Asynchronous reset with tokens queued
        a_dout_bp = 4'hF;
        push_a(8'hC1, 4'hF, w);
        push_a(8'hC2, 4'hF, w);
        a_valid = 1'b0;
        chk("ar_count_pre", a_dout_count, 8'hAA);
        #3;
        resetn = 1'b0;
        for (int i = 0; i < 4; i++) begin qa[i].delete(); qb[i].delete(); end
        #1;
        chk("ar_valid", a_dout_valid, 4'h0);
        chk("ar_count", a_dout_count, 8'h00);
        chk("ar_bp", a_bp, 1'b1);
        @(negedge clk);
        resetn = 1'b1;
        a_dout_bp = 4'h0;
        #1;
        chk("ar_release_bp", a_bp, 1'b0);
        repeat (3) @(negedge clk);
        chk("ar_no_ghost", a_dout_valid, 4'h0);

        // Depth=4 wrap-around with a consumer that toggles every cycle
        bmax = 0;
        b_dout_bp = 4'b0000;
        fork
            begin
                for (int t = 0; t < 10; t++) push_b(8'(t), 4'b0010, w);
                b_valid = 1'b0;
            end
            begin
                repeat (60) begin
                    @(negedge clk);
                    b_dout_bp[1] = ~b_dout_bp[1];
                end
            end
        join
        b_dout_bp = 4'b0000;
        repeat (6) @(negedge clk);
        chk("wr_max_count", bmax, 4);
        chk("wr_count_end", b_dout_count, 12'h000);

        for (int i = 0; i < 4; i++) begin
            chk("sb_a_empty", qa[i].size(), 0);
            chk("sb_b_empty", qb[i].size(), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
